// File: rtl/read_input_data_ocm.sv
// Purpose: reads NUM_WORDS 8-bit pixels from On-Chip RAM port s2 into a small
//          credit-limited FIFO and streams them to the pipeline with valid/ready.
// Latency: first out_dv RD_LATENCY+2 cycles after start is sampled; one read per
//          cycle while credit allows.
// Backpressure: out_ready low stalls pops; reads stop once FIFO level plus reads
//          in flight reach FIFO_DEPTH, so returning data always has a slot.
// Ports: clk/reset (sync, active-low), start, ocm0_* RAM read port,
//        out_data/out_dv/out_ready pipeline stream, busy/done/count status.

module read_input_data_ocm #(
   parameter int NUM_WORDS  = 784,
   parameter int BASE_ADDR  = 0,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ocm0_readdata,
   output logic [16:0] ocm0_addr,
   output logic        ocm0_chip,
   output logic        ocm0_clk_enab,
   output logic        ocm0_write,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_dv,
   output logic        busy,
   output logic        done,
   output logic [15:0] count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = LW + 1;
   localparam int IW = $clog2(RD_LATENCY + 1);

   localparam logic [15:0]   TOTAL    = 16'(NUM_WORDS);
   localparam logic [16:0]   BASE     = 17'(BASE_ADDR);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CREDITS  = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [15:0]           issued_q, issued_d;
   logic [15:0]           count_q, count_d;
   logic [16:0]           addr_q, addr_d;
   logic                  chip_q, chip_d;
   logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
   logic [LW-1:0]         level_q, level_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  dv_q, dv_d;
   logic [7:0]            fifo_mem [FIFO_DEPTH];

   logic [IW-1:0]         inflight;
   logic [CW-1:0]         occupancy;
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Slots already spoken for: words sitting in the FIFO plus reads whose data
   // is still travelling through the RAM pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + IW'(vpipe_q[i]);
      end
      occupancy = {1'b0, level_q} + CW'(inflight);
   end

   assign issue = (state_q == S_READ) && (issued_q < TOTAL) && (occupancy < CREDITS);
   // The oldest valid bit marks the cycle the RAM presents that read's data.
   assign push  = vpipe_q[RD_LATENCY-1];
   assign pop   = dv_q && out_ready;

   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      count_d  = count_q;
      chip_d   = 1'b1;
      level_d  = level_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      vpipe_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
      end

      if (issue) issued_d = issued_q + 16'd1;
      if (pop)   count_d  = count_q + 16'd1;

      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      dv_d = (level_d != '0);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_READ;
               issued_d = '0;
               count_d  = '0;
            end
         end
         S_READ:  if (issued_q == TOTAL) state_d = S_DRAIN;
         S_DRAIN: if ((count_q == TOTAL) && (level_q == '0)) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address is presented combinationally so the first read goes out in the
   // first READ cycle; between reads the last issued address is held.
   assign ocm0_addr     = issue ? (BASE + {1'b0, issued_q}) : addr_q;
   assign addr_d        = ocm0_addr;
   assign ocm0_clk_enab = issue;
   assign ocm0_write    = 1'b0;
   assign ocm0_chip     = chip_q;
   assign out_dv        = dv_q;
   assign out_data      = dv_q ? fifo_mem[rd_ptr_q] : 8'h00;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign count         = count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         issued_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         chip_q   <= 1'b0;
         vpipe_q  <= '0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         chip_q   <= chip_d;
         vpipe_q  <= vpipe_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dv_q     <= dv_d;
      end
   end

   // Storage needs no reset: out_data is masked until a word is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= ocm0_readdata;
   end

endmodule

// File: doc/read_input_data_ocm.md
READ_INPUT_DATA_OCM -- requirements
Module: read_input_data_ocm

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 784, number of 8-bit input pixels read per frame (range 1..65535).
REQ-002 SHALL have parameter BASE_ADDR, default 0, first On-Chip RAM word address of the frame.
REQ-003 SHALL have parameter RD_LATENCY, default 2, On-Chip RAM read latency in cycles (range 1..4).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (must be >= RD_LATENCY+1).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to read one frame.
REQ-008 ocm0_readdata  input  8  On-Chip RAM 0 s2 read data.
REQ-009 ocm0_addr  output  17  On-Chip RAM 0 s2 word address.
REQ-010 ocm0_chip  output  1  chip select, constant 1 when out of reset.
REQ-011 ocm0_clk_enab  output  1  read strobe; high only in cycles issuing a read.
REQ-012 ocm0_write  output  1  constant 0 (read-only port).
REQ-013 out_ready  input  1  downstream pipeline accepts out_data this cycle.
REQ-014 out_data  output  8  pixel to pipeline (pipeline in_data).
REQ-015 out_dv  output  1  out_data valid (pipeline in_dv).
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  one-cycle pulse after last word transferred.
REQ-018 count  output  16  words transferred to pipeline in current or last frame.

Function
REQ-019 States SHALL be IDLE, READ, DRAIN, DONE; IDLE -> READ when start=1; READ -> DRAIN when issued == NUM_WORDS; DRAIN -> DONE when count == NUM_WORDS and FIFO empty; DONE -> IDLE unconditionally.
REQ-020 On start accepted in IDLE, issued counter and count SHALL clear to 0; start SHALL be ignored in every other state.
REQ-021 In READ, a read SHALL issue in any cycle where issued < NUM_WORDS and fifo_level + inflight < FIFO_DEPTH: ocm0_clk_enab=1, ocm0_addr=(BASE_ADDR+issued) mod 2^17, issued incremented.
REQ-022 First read SHALL issue in the first cycle of READ (cycle after start sampled).
REQ-023 ocm0_readdata SHALL be written to the FIFO exactly RD_LATENCY cycles after its issue cycle, tracked by a RD_LATENCY-deep valid shift register.
REQ-024 out_dv SHALL equal FIFO non-empty (registered); out_data SHALL be FIFO head.
REQ-025 A transfer occurs when out_dv=1 and out_ready=1; FIFO pops, count increments by 1.
REQ-026 Words SHALL leave in address order; none dropped or duplicated under any out_ready pattern.
REQ-027 Simultaneous push and pop SHALL leave fifo_level unchanged; the credit rule of REQ-021 guarantees no overflow, so a full-FIFO push is not possible.
REQ-028 done SHALL be high exactly one cycle (state DONE); busy low in IDLE only.
REQ-029 ocm0_addr SHALL hold its last value when no read issues; ocm0_clk_enab=0 in IDLE, DRAIN, DONE.
REQ-030 count SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-031 reset=0 sampled SHALL force next cycle: state IDLE, FIFO empty, inflight valid pipe cleared, issued=0, count=0, ocm0_addr=0, ocm0_clk_enab=0, ocm0_write=0, ocm0_chip=0, out_data=0, out_dv=0, busy=0, done=0.
REQ-032 Read data returning after a mid-frame reset SHALL be discarded; reset has priority over start in the same cycle.
REQ-033 ocm0_chip SHALL be 1 from the first cycle after reset releases.

Verification
REQ-034 NUM_WORDS=8, RAM model data=addr[7:0]^8'hA5, out_ready=1: addresses 0..7 on consecutive cycles, out_data A5,A4,A7,A6,A1,A0,A3,A2, first out_dv RD_LATENCY+2 cycles after start sampled, done one pulse, count=8.
REQ-035 out_ready=0 for 20 cycles after start: exactly FIFO_DEPTH reads issued, out_dv held with out_data=A5; on release all 8 words in order, count=8.
REQ-036 Default parameters, out_ready toggling 1/0 each cycle: 784 words in order, ocm0_clk_enab high 784 cycles total, count=784, done single pulse.
REQ-037 reset=0 for one cycle during READ with 3 reads in flight: all outputs zero next cycle, no out_dv from stale data; subsequent start reads the full frame correctly.
REQ-038 start pulsed again during READ and DRAIN: ignored, frame completes with count=NUM_WORDS, no second frame.
REQ-039 BASE_ADDR=131070, NUM_WORDS=4: ocm0_addr sequence 131070, 131071, 0, 1; count=4.
